// File: rtl/eh2_posit_encode_pipe.sv
// eh2_posit_encode_pipe: two-stage posit encoder (regime build, then round/negate).
// Optional build macro: POSIT_ENC_SAT_EN -- out-of-range k saturates to +/-maxpos or
// +/-minpos instead of encoding NaR.
module eh2_posit_encode_pipe #(
  parameter int unsigned POSIT_LEN   = 16,
  parameter int unsigned ES          = 2,
  parameter int unsigned REGIME_BW   = $clog2(POSIT_LEN) + 1,
  parameter int unsigned FRACTION_BW = POSIT_LEN - ES
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_flush,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic                               i_in_sign,
  input  logic [REGIME_BW-1:0]               i_in_regime,
  input  logic [((ES == 0) ? 1 : ES)-1:0]    i_in_exponent,
  input  logic [FRACTION_BW-1:0]             i_in_fraction,
  input  logic                               i_in_sticky,
  input  logic                               i_in_nar,
  input  logic                               i_in_zero,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [POSIT_LEN-1:0]               o_out_posit,
  output logic                               o_out_sat
);

  localparam int unsigned N    = POSIT_LEN;
  localparam int unsigned EF   = ES + FRACTION_BW;
  localparam int unsigned TW   = 2 + EF + N;
  localparam int          KMAX = int'(POSIT_LEN) - 2;

  localparam logic [N-2:0] MAXPOS = '1;
  localparam logic [N-2:0] MINPOS = (N-1)'(1);
  localparam logic [N-1:0] NAR    = {1'b1, (N-1)'(0)};

  // Handshake
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_in_fire;

  // Stage 1 combinational
  logic signed [REGIME_BW-1:0] w_k;
  logic                        w_kneg;
  logic                        w_oor_hi;
  logic                        w_oor_lo;
  logic [EF-1:0]               w_ef;
  logic [TW-1:0]               w_seed;
  logic [REGIME_BW-1:0]        w_shamt;
  logic [TW-1:0]               w_str;

  // Stage 1 registers
  logic         r_s1_valid;
  logic [N-2:0] r_s1_mag;
  logic         r_s1_guard;
  logic         r_s1_sticky;
  logic         r_s1_sign;
  logic         r_s1_nar;
  logic         r_s1_zero;
  logic         r_s1_oor_hi;
  logic         r_s1_oor_lo;

  // Stage 2 combinational
  logic         w_round_up;
  logic         w_clamp_hi;
  logic         w_clamp_lo;
  logic [N-2:0] w_mag_rnd;
  logic [N-2:0] w_mag_sel;
  logic         w_nar_sel;
  logic [N-1:0] w_pos;
  logic [N-1:0] w_posit_nx;
  logic         w_sat_nx;

  // Stage 2 / output registers
  logic         r_s2_valid;
  logic [N-1:0] r_out_posit;
  logic         r_out_sat;

  assign w_s2_adv   = ~r_s2_valid | i_out_ready;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign o_in_ready = w_s1_adv & ~i_flush;
  assign w_in_fire  = i_in_valid & o_in_ready;

  assign w_k      = $signed(i_in_regime);
  assign w_kneg   = i_in_regime[REGIME_BW-1];
  assign w_oor_hi = int'(w_k) > KMAX;
  assign w_oor_lo = int'(w_k) < -KMAX;

  generate
    if (ES > 0) begin : g_exp
      assign w_ef = {i_in_exponent[ES-1:0], i_in_fraction};
    end else begin : g_noexp
      assign w_ef = i_in_fraction;
    end
  endgenerate

  // Regime seed "10" (k>=0) or "01" (k<0); arithmetic shift replicates the lead bit
  assign w_seed  = {~w_kneg, w_kneg, w_ef, {N{1'b0}}};
  assign w_shamt = w_kneg ? ~i_in_regime : i_in_regime;
  assign w_str   = $signed(w_seed) >>> w_shamt;

  // S1 valid: cleared by reset or flush, otherwise follows the input handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= i_in_valid;
    end
  end

  // S1 data: kept magnitude bits, guard, sticky and flags of an accepted beat
  always_ff @(posedge i_clk) begin
    if (w_in_fire) begin
      r_s1_mag    <= w_str[TW-1 -: N-1];
      r_s1_guard  <= w_str[TW-N];
      r_s1_sticky <= (|w_str[TW-N-1:0]) | i_in_sticky;
      r_s1_sign   <= i_in_sign;
      r_s1_nar    <= i_in_nar;
      r_s1_zero   <= i_in_zero;
      r_s1_oor_hi <= w_oor_hi;
      r_s1_oor_lo <= w_oor_lo;
    end
  end

  assign w_round_up = r_s1_guard & (r_s1_mag[0] | r_s1_sticky);
  assign w_clamp_hi = (&r_s1_mag) & (r_s1_guard | r_s1_sticky);
  assign w_clamp_lo = ~|r_s1_mag;
  assign w_mag_rnd  = r_s1_mag + (N-1)'(w_round_up);

  // S2 finish: range handling, clamps, sign, then NaR/zero override
  always_comb begin
    w_mag_sel  = w_mag_rnd;
    w_nar_sel  = 1'b0;
    w_sat_nx   = 1'b0;
    w_pos      = '0;
    w_posit_nx = '0;
    if (r_s1_oor_hi | r_s1_oor_lo) begin
      w_sat_nx = 1'b1;
`ifdef POSIT_ENC_SAT_EN
      w_mag_sel = r_s1_oor_hi ? MAXPOS : MINPOS;
`else
      w_nar_sel = 1'b1;
`endif
    end else if (w_clamp_hi) begin
      w_mag_sel = MAXPOS;
      w_sat_nx  = 1'b1;
    end else if (w_clamp_lo) begin
      w_mag_sel = MINPOS;
      w_sat_nx  = 1'b1;
    end
    w_pos      = {1'b0, w_mag_sel};
    w_posit_nx = r_s1_sign ? (~w_pos + N'(1)) : w_pos;
    if (w_nar_sel) begin
      w_posit_nx = NAR;
    end
    if (r_s1_nar) begin
      w_posit_nx = NAR;
      w_sat_nx   = 1'b0;
    end else if (r_s1_zero) begin
      w_posit_nx = '0;
      w_sat_nx   = 1'b0;
    end
  end

  // S2 output register: holds while stalled, cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid  <= 1'b0;
      r_out_posit <= '0;
      r_out_sat   <= 1'b0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_posit <= w_posit_nx;
        r_out_sat   <= w_sat_nx;
      end
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_out_posit = r_out_posit;
  assign o_out_sat   = r_out_sat;

endmodule

// File: tb/tb_eh2_posit_encode_pipe.sv
// Scoreboard bench for eh2_posit_encode_pipe at N=16, ES=2.
module tb_eh2_posit_encode_pipe;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_flush;
  logic              i_in_valid;
  logic              o_in_ready;
  logic              i_in_sign;
  logic [4:0]        i_in_regime;
  logic [1:0]        i_in_exponent;
  logic [13:0]       i_in_fraction;
  logic              i_in_sticky;
  logic              i_in_nar;
  logic              i_in_zero;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [15:0]       o_out_posit;
  logic              o_out_sat;

  typedef struct packed {
    logic [15:0] posit;
    logic        sat;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_ready = 1'b0;
  bit          have_held  = 1'b0;
  logic [15:0] held_posit;
  logic        held_sat;

`ifdef POSIT_ENC_SAT_EN
  localparam logic [15:0] E_HI_POS = 16'h7FFF;
  localparam logic [15:0] E_LO_POS = 16'h0001;
  localparam logic [15:0] E_LO_NEG = 16'hFFFF;
`else
  localparam logic [15:0] E_HI_POS = 16'h8000;
  localparam logic [15:0] E_LO_POS = 16'h8000;
  localparam logic [15:0] E_LO_NEG = 16'h8000;
`endif

  eh2_posit_encode_pipe #(.POSIT_LEN(16), .ES(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_sign     (i_in_sign),
    .i_in_regime   (i_in_regime),
    .i_in_exponent (i_in_exponent),
    .i_in_fraction (i_in_fraction),
    .i_in_sticky   (i_in_sticky),
    .i_in_nar      (i_in_nar),
    .i_in_zero     (i_in_zero),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_posit   (o_out_posit),
    .o_out_sat     (o_out_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Random consumer backpressure when enabled
  always @(posedge i_clk) begin
    #1;
    if (rand_ready) i_out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: in_ready model, stall stability, in-order scoreboard pop
  always @(negedge i_clk) begin
    if (i_rst) begin
      have_held = 1'b0;
    end else begin
      check("in_ready", 32'(o_in_ready), 32'(!i_flush && !(q.size() == 2 && !i_out_ready)));
      if (o_out_valid) begin
        if (have_held) begin
          check("stall_posit", 32'(o_out_posit), 32'(held_posit));
          check("stall_sat", 32'(o_out_sat), 32'(held_sat));
        end
        if (i_out_ready) begin
          have_held = 1'b0;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out: got 0x%0h with no beat expected", o_out_posit);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("out_posit", 32'(o_out_posit), 32'(e.posit));
            check("out_sat", 32'(o_out_sat), 32'(e.sat));
          end
        end else begin
          have_held  = 1'b1;
          held_posit = o_out_posit;
          held_sat   = o_out_sat;
        end
      end else begin
        have_held = 1'b0;
      end
    end
  end

  // Offer one beat starting at posedge+1; push its expected value once accepted
  task automatic send(input logic s, input logic [4:0] k, input logic [1:0] e,
                      input logic [13:0] f, input logic st, input logic nar,
                      input logic zero, input logic [15:0] ep, input logic esat);
    bit done = 1'b0;
    i_in_valid    = 1'b1;
    i_in_sign     = s;
    i_in_regime   = k;
    i_in_exponent = e;
    i_in_fraction = f;
    i_in_sticky   = st;
    i_in_nar      = nar;
    i_in_zero     = zero;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge i_clk);
      #1;
      if (o_in_ready) begin
        q.push_back('{posit: ep, sat: esat});
        done = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    i_in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat 0x%0h never accepted", ep);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(posedge i_clk);
      #1;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
    i_in_sign = 1'b0; i_in_regime = '0; i_in_exponent = '0; i_in_fraction = '0;
    i_in_sticky = 1'b0; i_in_nar = 1'b0; i_in_zero = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_out_valid", 32'(o_out_valid), 32'(0));
    check("rst_out_posit", 32'(o_out_posit), 32'(0));
    check("rst_out_sat", 32'(o_out_sat), 32'(0));
    check("rst_in_ready", 32'(o_in_ready), 32'(1));

    // Latency: beat driven after one edge is captured at the next, output one edge later
    send(1'b0, 5'sd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
    check("lat_not_yet", 32'(o_out_valid), 32'(0));
    @(posedge i_clk);
    #1;
    check("lat_valid", 32'(o_out_valid), 32'(1));
    drain();

    // Directed encodes
    send(1'b1, 5'sd0,   2'd0, 14'd0,               1'b0, 1'b0, 1'b0, 16'hC000, 1'b0);
    send(1'b0, 5'sd0,   2'd0, 14'b00000000000100,  1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
    send(1'b0, 5'sd0,   2'd0, 14'b00000000001100,  1'b0, 1'b0, 1'b0, 16'h4002, 1'b0);
    send(1'b0, 5'sd0,   2'd0, 14'b00000000000100,  1'b1, 1'b0, 1'b0, 16'h4001, 1'b0);
    send(1'b1, 5'sd0,   2'd0, 14'b00000000001100,  1'b0, 1'b0, 1'b0, 16'hBFFE, 1'b0);
    send(1'b0, 5'sd14,  2'd0, 14'h3FFF,            1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    send(1'b0, 5'sd13,  2'd3, 14'h3FFF,            1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0);
    send(1'b0, -5'sd14, 2'd0, 14'd0,               1'b0, 1'b0, 1'b0, 16'h0001, 1'b0);
    send(1'b1, -5'sd14, 2'd0, 14'd0,               1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    send(1'b0, -5'sd14, 2'd2, 14'd0,               1'b0, 1'b0, 1'b0, 16'h0002, 1'b0);
    // Out of range beyond the legal window
    send(1'b0, 5'sd15,  2'd0, 14'd0,               1'b0, 1'b0, 1'b0, E_HI_POS, 1'b1);
    send(1'b1, 5'b10000, 2'd0, 14'd0,              1'b0, 1'b0, 1'b0, E_LO_NEG, 1'b1);
    send(1'b0, 5'b10000, 2'd0, 14'd0,              1'b0, 1'b0, 1'b0, E_LO_POS, 1'b1);
    // Specials
    send(1'b0, 5'sd3,   2'd1, 14'h1234,            1'b0, 1'b1, 1'b1, 16'h8000, 1'b0);
    send(1'b1, 5'sd3,   2'd1, 14'h1234,            1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    send(1'b1, 5'sd15,  2'd0, 14'd0,               1'b0, 1'b1, 1'b0, 16'h8000, 1'b0);
    drain();

    // Backpressure: eight back-to-back beats under random out_ready
    rand_ready = 1'b1;
    send(1'b0, 5'sd0,   2'd0, 14'd0,              1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
    send(1'b1, 5'sd0,   2'd0, 14'd0,              1'b0, 1'b0, 1'b0, 16'hC000, 1'b0);
    send(1'b0, 5'sd0,   2'd0, 14'b00000000001100, 1'b0, 1'b0, 1'b0, 16'h4002, 1'b0);
    send(1'b0, 5'sd1,   2'd3, 14'd0,              1'b0, 1'b0, 1'b0, 16'h6C00, 1'b0);
    send(1'b0, -5'sd1,  2'd0, 14'd0,              1'b0, 1'b0, 1'b0, 16'h2000, 1'b0);
    send(1'b0, -5'sd14, 2'd0, 14'd0,              1'b0, 1'b0, 1'b0, 16'h0001, 1'b0);
    send(1'b0, -5'sd14, 2'd2, 14'd0,              1'b0, 1'b0, 1'b0, 16'h0002, 1'b0);
    send(1'b0, 5'sd13,  2'd3, 14'h3FFF,           1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0);
    drain();
    rand_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;

    // Flush with both stages full; the beat offered alongside must be dropped
    i_out_ready = 1'b0;
    send(1'b0, 5'sd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
    send(1'b1, 5'sd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'hC000, 1'b0);
    i_flush = 1'b1;
    i_in_valid = 1'b1;
    i_in_sign = 1'b0; i_in_regime = 5'sd1; i_in_exponent = 2'd3; i_in_fraction = '0;
    @(negedge i_clk);
    #1;
    check("flush_in_ready", 32'(o_in_ready), 32'(0));
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    q.delete();
    check("flush_out_valid", 32'(o_out_valid), 32'(0));
    i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      check("flush_no_accept", 32'(o_out_valid), 32'(0));
    end

    // Reset mid-stream discards in-flight beats and clears the output register
    i_out_ready = 1'b0;
    send(1'b0, 5'sd1, 2'd3, 14'd0, 1'b0, 1'b0, 1'b0, 16'h6C00, 1'b0);
    send(1'b0, 5'sd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("midrst_out_valid", 32'(o_out_valid), 32'(0));
    check("midrst_out_posit", 32'(o_out_posit), 32'(0));
    check("midrst_out_sat", 32'(o_out_sat), 32'(0));
    i_rst = 1'b0;
    q.delete();
    i_out_ready = 1'b1;
    send(1'b1, 5'sd1, 2'd3, 14'd0, 1'b0, 1'b0, 1'b0, 16'h9400, 1'b0);
    drain();
    repeat (3) @(posedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
